// File: rtl/tf_define.sv
// Shared twiddle-path definitions: lane geometry defaults and a lane-slice helper.
`ifndef TF_DEFINE_SV
`define TF_DEFINE_SV

// Width of one twiddle lane (D_width in the generator pipeline).
`define TF_D_WIDTH 64

// Radix-16 vector: fixed lane count.
`define TF_LANES 16

// Select lane k of a packed vector whose lanes are w bits wide.
`define TF_LANE(vec, k, w) vec[(k)*(w) +: (w)]

`endif

// File: rtl/tf_fifo_ptr.sv
// Pointer pair for the output FIFO: wrap-bit pointers, full/empty and occupancy.
module tf_fifo_ptr #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       push,
  input  logic                       pop,
  output logic [$clog2(DEPTH)-1:0]   wr_addr,
  output logic [$clog2(DEPTH)-1:0]   rd_addr,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // Advance pointers on accepted push/pop; clr wins over both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Full when only the wrap bits differ, empty when pointers match.
  always_comb begin
    wr_addr = wr_ptr[AW-1:0];
    rd_addr = rd_ptr[AW-1:0];
    full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    empty   = (wr_ptr == rd_ptr);
    level   = wr_ptr - rd_ptr;
  end

endmodule

// File: rtl/tf_out_buffer.sv
// Elastic output buffer for twiddle vectors: FIFO storage, stage-end tagging
// and sticky overflow flag toward the FFT butterfly consumer.
`ifndef TF_DEFINE_SV
`include "tf_define.sv"
`endif

module tf_out_buffer #(
  parameter int unsigned D_WIDTH = `TF_D_WIDTH,
  parameter int unsigned LANES   = `TF_LANES,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned GRP_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES*D_WIDTH-1:0]   in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES*D_WIDTH-1:0]   out_data,
  output logic                       out_last,
  input  logic [GRP_W-1:0]           grp_per_stage,
  input  logic                       clr,
  output logic                       ovf,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [LANES*D_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]            wr_addr;
  logic [AW-1:0]            rd_addr;
  logic                     full;
  logic                     empty;
  logic                     push;
  logic                     pop;
  logic [GRP_W-1:0]         grp_cnt;
  logic [GRP_W-1:0]         grp_limit;

  tf_fifo_ptr #(
    .DEPTH (DEPTH)
  ) u_ptr (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .push    (push),
    .pop     (pop),
    .wr_addr (wr_addr),
    .rd_addr (rd_addr),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  // Handshake decode; in_ready depends only on registered state, so a pop
  // on a full FIFO cannot admit a push in the same cycle.
  always_comb begin
    in_ready  = ~full;
    out_valid = ~empty;
    push      = in_valid & in_ready;
    pop       = out_valid & out_ready;
    out_data  = mem[rd_addr];
    out_last  = out_valid & (grp_cnt == grp_limit);
  end

  // Vector storage; not reset, contents behind rd_ptr are don't-care.
  always_ff @(posedge clk) begin
    if (push && !clr) mem[wr_addr] <= in_data;
  end

  // Stage group counter; the limit only reloads while idle at a stage boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grp_cnt   <= '0;
      grp_limit <= '0;
    end else if (clr) begin
      grp_cnt   <= '0;
      grp_limit <= grp_per_stage;
    end else begin
      if (pop) grp_cnt <= out_last ? '0 : grp_cnt + GRP_W'(1);
      if ((level == '0) && (grp_cnt == '0)) grp_limit <= grp_per_stage;
    end
  end

  // Sticky overflow: producer asserted valid while the buffer was full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (clr) begin
      ovf <= 1'b0;
    end else if (in_valid && !in_ready) begin
      ovf <= 1'b1;
    end
  end

endmodule
